// File: rtl/decode_pipe_pkg.sv
// Shared CHIP-8 decode types: op codes and the decoded-entry bundle.
// SUPER-CHIP codes are always present; DECODE_SCHIP_EN only gates decoding.
package decode_pipe_pkg;

  localparam int DEC_AW = 12;
  localparam int DEC_DW = 8;

  typedef enum logic [5:0] {
    OP_NOP      = 6'd0,
    OP_CLS      = 6'd1,
    OP_RET      = 6'd2,
    OP_JP       = 6'd3,
    OP_CALL     = 6'd4,
    OP_SE_I     = 6'd5,
    OP_SNE_I    = 6'd6,
    OP_SE_R     = 6'd7,
    OP_LD_I     = 6'd8,
    OP_ADD_I    = 6'd9,
    OP_LD_R     = 6'd10,
    OP_OR       = 6'd11,
    OP_AND      = 6'd12,
    OP_XOR      = 6'd13,
    OP_ADD_R    = 6'd14,
    OP_SUB      = 6'd15,
    OP_SHR      = 6'd16,
    OP_SUBN     = 6'd17,
    OP_SHL      = 6'd18,
    OP_SNE_R    = 6'd19,
    OP_LD_IDX   = 6'd20,
    OP_JP_V0    = 6'd21,
    OP_RND      = 6'd22,
    OP_DRW      = 6'd23,
    OP_SKP      = 6'd24,
    OP_SKNP     = 6'd25,
    OP_LD_VDT   = 6'd26,
    OP_LD_K     = 6'd27,
    OP_LD_DT    = 6'd28,
    OP_LD_ST    = 6'd29,
    OP_ADD_IDX  = 6'd30,
    OP_LD_F     = 6'd31,
    OP_LD_B     = 6'd32,
    OP_ST_REGS  = 6'd33,
    OP_LD_REGS  = 6'd34,
    OP_SCD      = 6'd35,
    OP_SCR      = 6'd36,
    OP_SCL      = 6'd37,
    OP_EXIT     = 6'd38,
    OP_LOW      = 6'd39,
    OP_HIGH     = 6'd40,
    OP_DRW16    = 6'd41,
    OP_LD_HF    = 6'd42,
    OP_ST_RPL   = 6'd43,
    OP_LD_RPL   = 6'd44,
    OP_ILLEGAL  = 6'h3F
  } op_e;

  typedef struct packed {
    op_e               op;
    logic [3:0]        x;
    logic [3:0]        y;
    logic [3:0]        n;
    logic [DEC_DW-1:0] vx;
    logic [DEC_DW-1:0] vy;
    logic [DEC_AW-1:0] pc;
  } dec_entry_t;

endpackage

// File: rtl/decode_pipe_if.sv
// Instruction-in / decoded-out handshake bundle of decode_pipe.
interface decode_pipe_if
  import decode_pipe_pkg::*;
#(
  parameter int AW = 12,
  parameter int DW = 8
);
  logic          in_valid;
  logic          in_ready;
  logic [15:0]   in_instr;
  logic [AW-1:0] in_pc;
  logic          out_valid;
  logic          out_ready;
  op_e           out_op;
  logic [3:0]    out_x;
  logic [3:0]    out_y;
  logic [3:0]    out_n;
  logic [7:0]    out_kk;
  logic [AW-1:0] out_nnn;
  logic [DW-1:0] out_vx;
  logic [DW-1:0] out_vy;
  logic [AW-1:0] out_pc;
  logic          decode_trap;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_op, out_x, out_y, out_n,
    input  out_kk, out_nnn, out_vx, out_vy, out_pc, decode_trap
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_op, out_x, out_y, out_n,
    output out_kk, out_nnn, out_vx, out_vy, out_pc, decode_trap
  );
endinterface

// File: rtl/decode_pipe_lut.sv
// CHIP-8 encoding to op_e map, purely combinational.
// DECODE_SCHIP_EN enables the SUPER-CHIP encodings.
module decode_lut
  import decode_pipe_pkg::*;
(
  input  logic [15:0] instr,
  output op_e         op
);
  logic [3:0] n;
  logic [7:0] kk;

  assign n  = instr[3:0];
  assign kk = instr[7:0];

  always_comb begin
    op = OP_ILLEGAL;
    case (instr[15:12])
      4'h0: begin
        if (instr == 16'h0000) op = OP_NOP;
        else if (instr == 16'h00E0) op = OP_CLS;
        else if (instr == 16'h00EE) op = OP_RET;
`ifdef DECODE_SCHIP_EN
        else if (instr[15:4] == 12'h00C) op = OP_SCD;
        else if (instr == 16'h00FB) op = OP_SCR;
        else if (instr == 16'h00FC) op = OP_SCL;
        else if (instr == 16'h00FD) op = OP_EXIT;
        else if (instr == 16'h00FE) op = OP_LOW;
        else if (instr == 16'h00FF) op = OP_HIGH;
`endif
      end
      4'h1: op = OP_JP;
      4'h2: op = OP_CALL;
      4'h3: op = OP_SE_I;
      4'h4: op = OP_SNE_I;
      4'h5: if (n == 4'h0) op = OP_SE_R;
      4'h6: op = OP_LD_I;
      4'h7: op = OP_ADD_I;
      4'h8: begin
        case (n)
          4'h0: op = OP_LD_R;
          4'h1: op = OP_OR;
          4'h2: op = OP_AND;
          4'h3: op = OP_XOR;
          4'h4: op = OP_ADD_R;
          4'h5: op = OP_SUB;
          4'h6: op = OP_SHR;
          4'h7: op = OP_SUBN;
          4'hE: op = OP_SHL;
          default: ;
        endcase
      end
      4'h9: if (n == 4'h0) op = OP_SNE_R;
      4'hA: op = OP_LD_IDX;
      4'hB: op = OP_JP_V0;
      4'hC: op = OP_RND;
`ifdef DECODE_SCHIP_EN
      4'hD: op = (n == 4'h0) ? OP_DRW16 : OP_DRW;
`else
      4'hD: op = OP_DRW;
`endif
      4'hE: begin
        if (kk == 8'h9E) op = OP_SKP;
        else if (kk == 8'hA1) op = OP_SKNP;
      end
      4'hF: begin
        case (kk)
          8'h07: op = OP_LD_VDT;
          8'h0A: op = OP_LD_K;
          8'h15: op = OP_LD_DT;
          8'h18: op = OP_LD_ST;
          8'h1E: op = OP_ADD_IDX;
          8'h29: op = OP_LD_F;
          8'h33: op = OP_LD_B;
          8'h55: op = OP_ST_REGS;
          8'h65: op = OP_LD_REGS;
`ifdef DECODE_SCHIP_EN
          8'h30: op = OP_LD_HF;
          8'h75: op = OP_ST_RPL;
          8'h85: op = OP_LD_RPL;
`endif
          default: ;
        endcase
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/decode_pipe.sv
// CHIP-8 decode stage: one-cycle decode, output + skid entry, sticky trap.
// DECODE_SCHIP_EN (see decode_lut) adds SUPER-CHIP decoding.
module decode_pipe
  import decode_pipe_pkg::*;
#(
  parameter int NREGS = 16,
  parameter int AW    = 12,
  parameter int DW    = 8,
  localparam int LW   = $clog2(NREGS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREGS*DW-1:0] registers,
  input  logic               wb_en,
  input  logic [LW-1:0]      wb_addr,
  input  logic [DW-1:0]      wb_data,
  input  logic               flush,
  input  logic               trap_clr,
  decode_pipe_if.slave       bus
);
  dec_entry_t out_q, out_d, skid_q, skid_d;
  dec_entry_t nw, ou_upd, sk_upd;
  logic       out_vld_q, out_vld_d;
  logic       skid_vld_q, skid_vld_d;
  logic       trap_q, trap_d;
  logic       in_rdy, acc, out_free;
  op_e        lut_op;

  decode_lut u_lut (
    .instr (bus.in_instr),
    .op    (lut_op)
  );

  // same-cycle writeback wins over the register file snapshot
  function automatic logic [DEC_DW-1:0] opnd(
    input logic [3:0]          i,
    input logic [NREGS*DW-1:0] rf,
    input logic                we,
    input logic [LW-1:0]       wa,
    input logic [DW-1:0]       wd
  );
    int unsigned idx;
    idx  = 32'(i);
    opnd = '0;
    if (idx < NREGS) begin
      if (we && wa == LW'(i)) opnd = DEC_DW'(wd);
      else opnd = DEC_DW'(rf[idx*DW +: DW]);
    end
  endfunction

  function automatic dec_entry_t upd(
    input dec_entry_t    e,
    input logic          we,
    input logic [LW-1:0] wa,
    input logic [DW-1:0] wd
  );
    upd = e;
    if (we && wa == LW'(e.x)) upd.vx = DEC_DW'(wd);
    if (we && wa == LW'(e.y)) upd.vy = DEC_DW'(wd);
  endfunction

  assign in_rdy   = !skid_vld_q && !trap_q;
  assign acc      = bus.in_valid && in_rdy;
  assign out_free = !out_vld_q || bus.out_ready;

  always_comb begin
    nw.op = lut_op;
    nw.x  = bus.in_instr[11:8];
    nw.y  = bus.in_instr[7:4];
    nw.n  = bus.in_instr[3:0];
    nw.vx = opnd(bus.in_instr[11:8], registers, wb_en, wb_addr, wb_data);
    nw.vy = opnd(bus.in_instr[7:4], registers, wb_en, wb_addr, wb_data);
    nw.pc = DEC_AW'(bus.in_pc);
    ou_upd = upd(out_q, wb_en, wb_addr, wb_data);
    sk_upd = upd(skid_q, wb_en, wb_addr, wb_data);
  end

  always_comb begin
    out_d      = out_q;
    out_vld_d  = out_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    trap_d     = trap_q;
    if (flush) begin
      out_vld_d  = 1'b0;
      skid_vld_d = 1'b0;
      trap_d     = 1'b0;
    end else begin
      trap_d = (trap_q && !trap_clr) || (acc && lut_op == OP_ILLEGAL);
      unique case (1'b1)
        out_free && skid_vld_q: begin
          out_d      = sk_upd;
          out_vld_d  = 1'b1;
          skid_vld_d = 1'b0;
        end
        out_free && !skid_vld_q && acc: begin
          out_d     = nw;
          out_vld_d = 1'b1;
        end
        out_free && !skid_vld_q && !acc: begin
          out_vld_d = 1'b0;
        end
        !out_free: begin
          out_d  = ou_upd;
          skid_d = sk_upd;
          if (acc) begin
            skid_d     = nw;
            skid_vld_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q      <= '0;
      out_vld_q  <= 1'b0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
      trap_q     <= 1'b0;
    end else begin
      out_q      <= out_d;
      out_vld_q  <= out_vld_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
      trap_q     <= trap_d;
    end
  end

  assign bus.in_ready    = in_rdy;
  assign bus.out_valid   = out_vld_q;
  assign bus.out_op      = out_q.op;
  assign bus.out_x       = out_q.x;
  assign bus.out_y       = out_q.y;
  assign bus.out_n       = out_q.n;
  assign bus.out_kk      = {out_q.y, out_q.n};
  assign bus.out_nnn     = AW'({out_q.x, out_q.y, out_q.n});
  assign bus.out_vx      = DW'(out_q.vx);
  assign bus.out_vy      = DW'(out_q.vy);
  assign bus.out_pc      = AW'(out_q.pc);
  assign bus.decode_trap = trap_q;
endmodule

// File: tb/tb_decode_pipe.sv
// Randomized scoreboard bench for decode_pipe with a mask/match reference
// decoder and a queue model of the held entries.
module tb_decode_pipe;
  import decode_pipe_pkg::*;

  localparam int NREGS = 16;
  localparam int AW    = 12;
  localparam int DW    = 8;
  localparam int LW    = 4;

  typedef struct {
    op_e           op;
    logic [15:0]   instr;
    logic [AW-1:0] pc;
    logic [DW-1:0] vx;
    logic [DW-1:0] vy;
  } exp_t;

  typedef struct {
    logic [15:0] mask;
    logic [15:0] match;
    op_e         op;
  } pat_t;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREGS*DW-1:0] registers;
  logic                wb_en;
  logic [LW-1:0]       wb_addr;
  logic [DW-1:0]       wb_data;
  logic                flush;
  logic                trap_clr;

  decode_pipe_if #(.AW(AW), .DW(DW)) bus ();

  decode_pipe #(.NREGS(NREGS), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .registers (registers),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .flush     (flush),
    .trap_clr  (trap_clr),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  exp_t          q[$];
  pat_t          pats[$];
  logic [DW-1:0] rf[NREGS];
  bit            trap_m;
  bit            mon_en;
  int            total;
  int            bad;
  exp_t          me;

  task automatic addp(input logic [15:0] m, input logic [15:0] v, input op_e o);
    pat_t p;
    p.mask  = m;
    p.match = v;
    p.op    = o;
    pats.push_back(p);
  endtask

  function automatic op_e model_op(input logic [15:0] ins);
    foreach (pats[i])
      if ((ins & pats[i].mask) == pats[i].match) return pats[i].op;
    return OP_ILLEGAL;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("out_valid", bus.out_valid, q.size() != 0);
      chk("decode_trap", bus.decode_trap, trap_m);
      if (bus.out_valid && bus.out_ready && q.size() != 0) begin
        me = q.pop_front();
        total++;
        if (bus.out_op !== me.op || bus.out_x !== me.instr[11:8] ||
            bus.out_y !== me.instr[7:4] || bus.out_n !== me.instr[3:0] ||
            bus.out_kk !== me.instr[7:0] ||
            bus.out_nnn !== me.instr[11:0] ||
            bus.out_vx !== me.vx || bus.out_vy !== me.vy ||
            bus.out_pc !== me.pc) begin
          bad++;
          $display("FAIL out_entry: got op=%0h i=%h%h%h nnn=%h kk=%h vx=%h vy=%h pc=%h want op=%0h i=%h vx=%h vy=%h pc=%h",
                   bus.out_op, bus.out_x, bus.out_y, bus.out_n, bus.out_nnn,
                   bus.out_kk, bus.out_vx, bus.out_vy, bus.out_pc,
                   me.op, me.instr[11:0], me.vx, me.vy, me.pc);
        end
      end
    end
  end

  // one clock cycle, entered and left at posedge+1
  task automatic cyc(input bit v, input logic [15:0] ins,
                     input logic [AW-1:0] pc, input bit ordy,
                     input bit we, input logic [LW-1:0] wa,
                     input logic [DW-1:0] wd, input bit fl, input bit tc);
    bit   exp_rdy;
    bit   acc;
    exp_t e;
    for (int i = 0; i < NREGS; i++) registers[i*DW +: DW] = rf[i];
    bus.in_valid  = v;
    bus.in_instr  = ins;
    bus.in_pc     = pc;
    bus.out_ready = ordy;
    wb_en         = we;
    wb_addr       = wa;
    wb_data       = wd;
    flush         = fl;
    trap_clr      = tc;
    exp_rdy = (q.size() < 2) && !trap_m;
    chk("in_ready", bus.in_ready, exp_rdy);
    acc = v && exp_rdy && !fl;
    @(negedge clk);
    #1;
    if (fl) begin
      q.delete();
      trap_m = 1'b0;
    end else begin
      e.op    = model_op(ins);
      e.instr = ins;
      e.pc    = pc;
      e.vx    = rf[ins[11:8]];
      e.vy    = rf[ins[7:4]];
      if (acc) q.push_back(e);
      if (we) begin
        foreach (q[i]) begin
          if (q[i].instr[11:8] == wa) q[i].vx = wd;
          if (q[i].instr[7:4] == wa) q[i].vy = wd;
        end
      end
      trap_m = (trap_m && !tc) || (acc && e.op == OP_ILLEGAL);
    end
    if (we) rf[wa] = wd;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit ordy);
    cyc(1'b0, 16'h0, '0, ordy, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic put(input logic [15:0] ins, input logic [AW-1:0] pc,
                     input bit ordy);
    cyc(1'b1, ins, pc, ordy, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    pat_t p;
    logic [15:0] ins;
    total  = 0;
    bad    = 0;
    trap_m = 1'b0;
    mon_en = 1'b0;

    addp(16'hFFFF, 16'h0000, OP_NOP);
    addp(16'hFFFF, 16'h00E0, OP_CLS);
    addp(16'hFFFF, 16'h00EE, OP_RET);
    addp(16'hF000, 16'h1000, OP_JP);
    addp(16'hF000, 16'h2000, OP_CALL);
    addp(16'hF000, 16'h3000, OP_SE_I);
    addp(16'hF000, 16'h4000, OP_SNE_I);
    addp(16'hF00F, 16'h5000, OP_SE_R);
    addp(16'hF000, 16'h6000, OP_LD_I);
    addp(16'hF000, 16'h7000, OP_ADD_I);
    addp(16'hF00F, 16'h8000, OP_LD_R);
    addp(16'hF00F, 16'h8001, OP_OR);
    addp(16'hF00F, 16'h8002, OP_AND);
    addp(16'hF00F, 16'h8003, OP_XOR);
    addp(16'hF00F, 16'h8004, OP_ADD_R);
    addp(16'hF00F, 16'h8005, OP_SUB);
    addp(16'hF00F, 16'h8006, OP_SHR);
    addp(16'hF00F, 16'h8007, OP_SUBN);
    addp(16'hF00F, 16'h800E, OP_SHL);
    addp(16'hF00F, 16'h9000, OP_SNE_R);
    addp(16'hF000, 16'hA000, OP_LD_IDX);
    addp(16'hF000, 16'hB000, OP_JP_V0);
    addp(16'hF000, 16'hC000, OP_RND);
`ifdef DECODE_SCHIP_EN
    addp(16'hFFF0, 16'h00C0, OP_SCD);
    addp(16'hFFFF, 16'h00FB, OP_SCR);
    addp(16'hFFFF, 16'h00FC, OP_SCL);
    addp(16'hFFFF, 16'h00FD, OP_EXIT);
    addp(16'hFFFF, 16'h00FE, OP_LOW);
    addp(16'hFFFF, 16'h00FF, OP_HIGH);
    addp(16'hF00F, 16'hD000, OP_DRW16);
    addp(16'hF0FF, 16'hF030, OP_LD_HF);
    addp(16'hF0FF, 16'hF075, OP_ST_RPL);
    addp(16'hF0FF, 16'hF085, OP_LD_RPL);
`endif
    addp(16'hF000, 16'hD000, OP_DRW);
    addp(16'hF0FF, 16'hE09E, OP_SKP);
    addp(16'hF0FF, 16'hE0A1, OP_SKNP);
    addp(16'hF0FF, 16'hF007, OP_LD_VDT);
    addp(16'hF0FF, 16'hF00A, OP_LD_K);
    addp(16'hF0FF, 16'hF015, OP_LD_DT);
    addp(16'hF0FF, 16'hF018, OP_LD_ST);
    addp(16'hF0FF, 16'hF01E, OP_ADD_IDX);
    addp(16'hF0FF, 16'hF029, OP_LD_F);
    addp(16'hF0FF, 16'hF033, OP_LD_B);
    addp(16'hF0FF, 16'hF055, OP_ST_REGS);
    addp(16'hF0FF, 16'hF065, OP_LD_REGS);

    for (int i = 0; i < NREGS; i++) rf[i] = 8'($urandom);
    registers     = '0;
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.in_pc     = '0;
    bus.out_ready = 1'b0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    flush = 1'b0; trap_clr = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_trap", bus.decode_trap, 1'b0);
    chk("rst_data", {bus.out_op, bus.out_x, bus.out_y, bus.out_n, bus.out_kk,
                     bus.out_nnn, bus.out_vx, bus.out_vy, bus.out_pc}, '0);
    rst = 1'b0;
    chk("rst_in_ready", bus.in_ready, 1'b1);
    mon_en = 1'b1;

    // load-immediate decode and one-cycle latency
    put(16'h6A42, 12'h200, 1'b1);
    chk("ld_op", bus.out_op, OP_LD_I);
    chk("ld_x", bus.out_x, 4'hA);
    chk("ld_kk", bus.out_kk, 8'h42);
    chk("ld_pc", bus.out_pc, 12'h200);
    idle(1'b1);

    // stalled output: two accepted, third refused, then in-order drain
    put(16'h1111, 12'h010, 1'b0);
    put(16'h2222, 12'h012, 1'b0);
    put(16'h3333, 12'h014, 1'b0);
    chk("full_in_ready", bus.in_ready, 1'b0);
    repeat (3) idle(1'b1);

    // writeback bypass at accept and update of a held entry
    cyc(1'b1, 16'h8124, 12'h300, 1'b0, 1'b1, 4'd2, 8'h55, 1'b0, 1'b0);
    chk("bypass_vy", bus.out_vy, 8'h55);
    cyc(1'b0, 16'h0, '0, 1'b0, 1'b1, 4'd1, 8'h9C, 1'b0, 1'b0);
    chk("held_vx", bus.out_vx, 8'h9C);
    idle(1'b1);
    idle(1'b1);

    // illegal 5xyN traps and blocks input until trap_clr
    put(16'h5121, 12'h400, 1'b1);
    chk("ill_op", bus.out_op, OP_ILLEGAL);
    chk("ill_trap", bus.decode_trap, 1'b1);
    chk("ill_in_ready", bus.in_ready, 1'b0);
    cyc(1'b1, 16'h6000, 12'h402, 1'b1, 1'b0, '0, '0, 1'b0, 1'b1);
    chk("clr_in_ready", bus.in_ready, 1'b1);
    idle(1'b1);

    // flush with both entries full and input offered
    put(16'h7105, 12'h500, 1'b0);
    put(16'h7206, 12'h502, 1'b0);
    cyc(1'b1, 16'h7307, 12'h504, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    chk("flush_out_valid", bus.out_valid, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // 00FF: hires under SUPER-CHIP, illegal otherwise
    put(16'h00FF, 12'h600, 1'b1);
`ifdef DECODE_SCHIP_EN
    chk("schip_high", bus.out_op, OP_HIGH);
`else
    chk("schip_high", bus.out_op, OP_ILLEGAL);
`endif
    cyc(1'b0, 16'h0, '0, 1'b1, 1'b0, '0, '0, 1'b0, 1'b1);
    idle(1'b1);

    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 1) == 0) begin
        ins = 16'($urandom);
      end else begin
        p   = pats[$urandom_range(0, pats.size() - 1)];
        ins = (16'($urandom) & ~p.mask) | p.match;
      end
      cyc($urandom_range(0, 9) < 7, ins, AW'($urandom),
          $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 3,
          LW'($urandom), DW'($urandom), $urandom_range(0, 49) == 0,
          $urandom_range(0, 3) == 0);
    end

    // reset while two entries are held
    cyc(1'b0, 16'h0, '0, 1'b1, 1'b0, '0, '0, 1'b1, 1'b0);
    put(16'h6111, 12'h700, 1'b0);
    put(16'h6222, 12'h702, 1'b0);
    mon_en = 1'b0;
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", bus.out_valid, 1'b0);
    chk("mid_rst_ready", bus.in_ready, 1'b1);
    q.delete();
    trap_m = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;
    put(16'hA123, 12'h800, 1'b1);

    for (int k = 0; k < 10 && q.size() != 0; k++) idle(1'b1);
    chk("drain_empty", q.size(), 0);
    idle(1'b1);
    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
